wb_retire_trace: RTL and testbench
==================================

Name: wb_retire_trace

Overview:
- Sits directly downstream of the pipeline top. Consumes the write-back (WB) stage outputs every cycle.
- Filters out pipeline bubbles, packs each retired instruction into a trace record and buffers it in a show-ahead FIFO.
- Drains records to the monitor or trace sink over a valid/ready handshake.
- Keeps retire, drop and overflow statistics for the verification monitor.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- BUBBLE0, 32'h0000_0013: first instruction encoding treated as a bubble (canonical NOP).
- BUBBLE1, 32'h0000_0000: second instruction encoding treated as a bubble (flushed slot).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_pc  in  32  PC of the instruction in WB.
- wb_instruction  in  32  instruction in WB.
- wb_write_data  in  32  register write-back data.
- wb_rd_addr  in  5  destination register.
- wb_RegWrite  in  1  register write enable.
- wb_MemWrite  in  1  memory write enable.
- wb_mem_addr  in  32  store address.
- wb_mem_wdata  in  32  store data.
- clear  in  1  synchronous FIFO flush; does not clear counters.
- out_valid  out  1  head record available.
- out_ready  in  1  sink accepts the head record.
- out_pc, out_instr, out_wdata, out_maddr, out_mdata  out  32 each  head record fields.
- out_rd  out  5  head record destination register.
- out_regwr, out_memwr  out  1 each  head record write flags.
- occupancy  out  $clog2(DEPTH)+1  number of entries stored.
- retired_count  out  32  records accepted into the FIFO.
- dropped_count  out  32  records lost because the FIFO was full.
- overflow  out  1  sticky flag; set on the first drop.

Behaviour:
- retire = (wb_instruction != BUBBLE0) && (wb_instruction != BUBBLE1). A genuine program NOP is not traced; this is intended.
- Record fields:
  - out_regwr is stored as wb_RegWrite && (wb_rd_addr != 0).
  - out_rd and out_wdata are stored as 0 when out_regwr = 0.
  - out_maddr and out_mdata are stored as 0 when wb_MemWrite = 0.
- push = retire && !clear. pop = out_valid && out_ready && !clear.
- Push accepted when occupancy < DEPTH, or when occupancy = DEPTH and pop occurs in the same cycle (simultaneous push/pop on full is allowed).
- Accepted push: write at wr_ptr, increment wr_ptr mod DEPTH, increment retired_count (wraps at 2^32).
- Rejected push: increment dropped_count (wraps) and set overflow. The FIFO is left unchanged.
- Pop: increment rd_ptr mod DEPTH.
- Occupancy update per cycle: push-only +1, pop-only -1, both or neither unchanged.
- Latency: a record presented to the WB inputs at edge N is visible at the outputs with out_valid = 1 after edge N, i.e. cycle N+1.
  - With an empty FIFO, zero-cycle bypass is not required.
- Show-ahead: out_* are driven from the head entry while occupancy > 0.
  - When empty: out_valid = 0 and all out_* fields = 0.
  - Head fields stay stable while out_valid && !out_ready.
- Pop on empty is impossible, since pop requires out_valid.
- clear: at the edge, rd_ptr, wr_ptr and occupancy go to 0.
  - A retire in the same cycle is discarded and not counted as retired or dropped.
  - Counters and overflow are held.
- reset (priority over clear):
  - pointers, occupancy, retired_count, dropped_count = 0; overflow = 0.
  - out_valid = 0 and all out_* = 0 in the following cycle.
  - Storage array contents need no reset.
- Reset asserted mid-stream: any record in WB during the reset cycle is discarded.

Decomposition:
- Package wb_trace_pkg holds:
  - REC_W = 167: pc 32 + instr 32 + regwr 1 + memwr 1 + rd 5 + wdata 32 + maddr 32 + mdata 32.
  - Field offset constants in that order.
  - Default bubble encodings.
  - Pack/unpack functions.
- Sub-module sync_fifo (WIDTH, DEPTH): storage, pointers, occupancy, full/empty, show-ahead read.
  - Instantiated with WIDTH = REC_W.
- Top level holds the filter, packing and counters.

Test Plan:
- Reset, then retire pc=0x0, instr=0x00500093 (addi x1,x0,5), RegWrite=1, rd=1, data=5 with out_ready=1:
  - out_valid=1 one cycle later with out_pc=0, out_rd=1, out_wdata=5.
  - retired_count=1.
- Stream alternating instr=0x00000013 and real instructions for 10 cycles:
  - only the 5 real instructions are traced; bubbles are never counted.
- Store sw x2,8(x0) with MemWrite=1, addr=0x8, wdata=0xDEADBEEF, RegWrite=0:
  - out_memwr=1, out_maddr=0x8, out_mdata=0xDEADBEEF, out_regwr=0, out_rd=0.
- out_ready=0, retire 18 instructions with DEPTH=16:
  - occupancy=16, dropped_count=2, overflow=1.
  - Head remains the first record.
- At full (occupancy 16), out_ready=1 with a simultaneous retire:
  - push accepted, occupancy stays 16, dropped_count unchanged.
- With occupancy 5, assert clear together with a retire:
  - next cycle occupancy=0, out_valid=0.
  - retired_count unchanged by that cycle.
  - Then assert reset: all counters = 0.
- Retire with rd=0 and RegWrite=1:
  - record shows out_regwr=0, out_wdata=0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - trace record layout, default bubble encodings, pack/unpack helpers
// The record is a flat 167-bit vector. pc sits at bit 0, and each later field sits
// above the one before it: pc, instr, regwr, memwr, rd, wdata, maddr, mdata.
package wb_trace_pkg;

  localparam int REC_W = 167;

  localparam int OFF_PC    = 0;
  localparam int OFF_INSTR = 32;
  localparam int OFF_REGWR = 64;
  localparam int OFF_MEMWR = 65;
  localparam int OFF_RD    = 66;
  localparam int OFF_WDATA = 71;
  localparam int OFF_MADDR = 103;
  localparam int OFF_MDATA = 135;

  localparam logic [31:0] DEF_BUBBLE0 = 32'h0000_0013;
  localparam logic [31:0] DEF_BUBBLE1 = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        regwr;
    logic        memwr;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic [31:0] mdata;
  } trace_rec_t;

  function automatic logic [REC_W-1:0] pack_rec(input trace_rec_t r);
    logic [REC_W-1:0] v;
    v = '0;
    v[OFF_PC    +: 32] = r.pc;
    v[OFF_INSTR +: 32] = r.instr;
    v[OFF_REGWR]       = r.regwr;
    v[OFF_MEMWR]       = r.memwr;
    v[OFF_RD    +: 5]  = r.rd;
    v[OFF_WDATA +: 32] = r.wdata;
    v[OFF_MADDR +: 32] = r.maddr;
    v[OFF_MDATA +: 32] = r.mdata;
    return v;
  endfunction

  function automatic trace_rec_t unpack_rec(input logic [REC_W-1:0] v);
    trace_rec_t r;
    r.pc    = v[OFF_PC    +: 32];
    r.instr = v[OFF_INSTR +: 32];
    r.regwr = v[OFF_REGWR];
    r.memwr = v[OFF_MEMWR];
    r.rd    = v[OFF_RD    +: 5];
    r.wdata = v[OFF_WDATA +: 32];
    r.maddr = v[OFF_MADDR +: 32];
    r.mdata = v[OFF_MDATA +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with flush
// Ports: clk and reset (synchronous, active-high). clear flushes the pointers.
// wr_en/wr_data carry the push. rd_en pops the head. rd_data is the head entry,
// or zero when the FIFO is empty. count, full and empty report the fill level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A write while full is only legal if the head leaves in the same cycle.
  assign wr_ok = wr_en && !clear && (!full || rd_en);
  assign rd_ok = rd_en && !clear && !empty;

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage array has no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/wb_retire_trace.sv
// rtl/wb_retire_trace.sv - filters WB bubbles, packs trace records, buffers them and drains to a sink
// Ports: clk and reset (synchronous, active-high). wb_* is the write-back stage bundle.
// clear flushes the FIFO. The out_* fields, out_valid and out_ready form the drain
// handshake. occupancy, retired_count, dropped_count and overflow are the statistics.
module wb_retire_trace
  import wb_trace_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] BUBBLE0 = DEF_BUBBLE0,
  parameter logic [31:0] BUBBLE1 = DEF_BUBBLE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            wb_pc,
  input  logic [31:0]            wb_instruction,
  input  logic [31:0]            wb_write_data,
  input  logic [4:0]             wb_rd_addr,
  input  logic                   wb_RegWrite,
  input  logic                   wb_MemWrite,
  input  logic [31:0]            wb_mem_addr,
  input  logic [31:0]            wb_mem_wdata,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_wdata,
  output logic [31:0]            out_maddr,
  output logic [31:0]            out_mdata,
  output logic [4:0]             out_rd,
  output logic                   out_regwr,
  output logic                   out_memwr,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            retired_count,
  output logic [31:0]            dropped_count,
  output logic                   overflow
);

  logic             retire, push, pop, accept;
  logic             fifo_full, fifo_empty;
  trace_rec_t       rec_in, head;
  logic [REC_W-1:0] head_vec;
  logic [31:0]      retired_q, retired_d;
  logic [31:0]      dropped_q, dropped_d;
  logic             overflow_q, overflow_d;

  // Both the canonical NOP and the flushed all-zero slot count as bubbles.
  assign retire = (wb_instruction != BUBBLE0) && (wb_instruction != BUBBLE1);
  assign push   = retire && !clear;
  assign pop    = out_valid && out_ready && !clear;
  assign accept = push && (!fifo_full || pop);

  // Fields with no architectural effect are zeroed so records compare cleanly.
  always_comb begin
    rec_in       = '0;
    rec_in.pc    = wb_pc;
    rec_in.instr = wb_instruction;
    rec_in.regwr = wb_RegWrite && (wb_rd_addr != 5'd0);
    rec_in.memwr = wb_MemWrite;
    if (rec_in.regwr) begin
      rec_in.rd    = wb_rd_addr;
      rec_in.wdata = wb_write_data;
    end
    if (wb_MemWrite) begin
      rec_in.maddr = wb_mem_addr;
      rec_in.mdata = wb_mem_wdata;
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (pack_rec(rec_in)),
    .rd_en   (pop),
    .rd_data (head_vec),
    .count   (occupancy),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head      = unpack_rec(head_vec);
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_wdata = head.wdata;
  assign out_maddr = head.maddr;
  assign out_mdata = head.mdata;
  assign out_rd    = head.rd;
  assign out_regwr = head.regwr;
  assign out_memwr = head.memwr;

  always_comb begin
    retired_d  = retired_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    if (accept) begin
      retired_d = retired_q + 32'd1;
    end else if (push) begin
      dropped_d  = dropped_q + 32'd1;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q  <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      retired_q  <= retired_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  assign retired_count = retired_q;
  assign dropped_count = dropped_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_wb_retire_trace.sv
// tb/tb_wb_retire_trace.sv - self-checking bench for wb_retire_trace against a queue model
module tb_wb_retire_trace;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_pc = '0, wb_instruction = '0, wb_write_data = '0;
  logic [4:0]  wb_rd_addr = '0;
  logic        wb_RegWrite = 1'b0, wb_MemWrite = 1'b0;
  logic [31:0] wb_mem_addr = '0, wb_mem_wdata = '0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_instr, out_wdata, out_maddr, out_mdata;
  logic [4:0]  out_rd;
  logic        out_regwr, out_memwr;
  logic [4:0]  occupancy;
  logic [31:0] retired_count, dropped_count;
  logic        overflow;

  wb_retire_trace #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_pc(wb_pc), .wb_instruction(wb_instruction), .wb_write_data(wb_write_data),
    .wb_rd_addr(wb_rd_addr), .wb_RegWrite(wb_RegWrite), .wb_MemWrite(wb_MemWrite),
    .wb_mem_addr(wb_mem_addr), .wb_mem_wdata(wb_mem_wdata), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_wdata(out_wdata),
    .out_maddr(out_maddr), .out_mdata(out_mdata), .out_rd(out_rd),
    .out_regwr(out_regwr), .out_memwr(out_memwr), .occupancy(occupancy),
    .retired_count(retired_count), .dropped_count(dropped_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, wdata, maddr, mdata;
    logic [4:0]  rd;
    logic        regwr, memwr;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] m_ret = '0, m_drop = '0;
  logic        m_ovf = 1'b0;
  int          n_tests = 0, n_fail = 0;

  function automatic rec_t head_exp();
    rec_t r;
    r = '{default: '0};
    if (mq.size() > 0) r = mq[0];
    return r;
  endfunction

  // Model the trace behaviour from the current inputs, then advance one clock.
  task automatic step();
    bit   ret, push, pop;
    rec_t r;
    ret  = (wb_instruction != 32'h13) && (wb_instruction != 32'h0);
    push = ret && !clear;
    pop  = (mq.size() > 0) && out_ready && !clear;
    r.pc    = wb_pc;
    r.instr = wb_instruction;
    r.regwr = wb_RegWrite && (wb_rd_addr != 0);
    r.rd    = r.regwr ? wb_rd_addr : 5'd0;
    r.wdata = r.regwr ? wb_write_data : 32'd0;
    r.memwr = wb_MemWrite;
    r.maddr = wb_MemWrite ? wb_mem_addr : 32'd0;
    r.mdata = wb_MemWrite ? wb_mem_wdata : 32'd0;
    if (reset) begin
      mq.delete(); m_ret = 0; m_drop = 0; m_ovf = 0;
    end else if (clear) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) begin mq.push_back(r); m_ret++; end
        else begin m_drop++; m_ovf = 1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic mw,
                       input logic [31:0] ma, input logic [31:0] md);
    wb_pc = pc; wb_instruction = instr; wb_write_data = wd; wb_rd_addr = rd;
    wb_RegWrite = rw; wb_MemWrite = mw; wb_mem_addr = ma; wb_mem_wdata = md;
  endtask

  task automatic idle();
    drive(32'h0, 32'h13, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle(); clear = 0; reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset();
    out_ready = 0;
    do_reset();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0 || retired_count !== 32'd0 ||
        dropped_count !== 32'd0 || overflow !== 1'b0 || out_pc !== 32'd0 || out_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%0b occ=%0d ret=%0d drop=%0d ovf=%0b pc=%h wdata=%h expected all zero",
               out_valid, occupancy, retired_count, dropped_count, overflow, out_pc, out_wdata);
    end
  endtask

  task automatic test_single_retire();
    out_ready = 1;
    drive(32'h0, 32'h0050_0093, 32'd5, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0);
    step(); idle();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_rd !== 5'd1 || out_wdata !== 32'd5 ||
        out_instr !== 32'h0050_0093 || out_regwr !== 1'b1 || retired_count !== 32'd1) begin
      n_fail++;
      $display("FAIL single_retire: valid=%0b pc=%h rd=%0d wdata=%0d instr=%h regwr=%0b ret=%0d expected 1/0/1/5/00500093/1/1",
               out_valid, out_pc, out_rd, out_wdata, out_instr, out_regwr, retired_count);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0) begin
      n_fail++;
      $display("FAIL single_drain: valid=%0b occ=%0d expected 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] v;
    logic [31:0] ret0;
    out_ready = 0;
    ret0 = retired_count;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) idle();
      else begin
        v = $urandom; v[6:0] = 7'h33;
        drive(32'h100 + 4 * i, v, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 32'h0, 32'h0);
      end
      step();
    end
    idle();
    n_tests++;
    if (occupancy !== 5'd5 || retired_count !== ret0 + 32'd5 || dropped_count !== 32'd0) begin
      n_fail++;
      $display("FAIL bubbles_count: occ=%0d ret_delta=%0d drop=%0d expected 5/5/0",
               occupancy, retired_count - ret0, dropped_count);
    end
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      rec_t e;
      e = head_exp();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr ||
          out_rd !== e.rd || out_wdata !== e.wdata) begin
        n_fail++;
        $display("FAIL bubbles_drain[%0d]: valid=%0b pc=%h instr=%h rd=%0d wdata=%h expected 1 %h %h %0d %h",
                 i, out_valid, out_pc, out_instr, out_rd, out_wdata, e.pc, e.instr, e.rd, e.wdata);
      end
      step();
    end
  endtask

  task automatic test_store();
    out_ready = 1;
    drive(32'h200, 32'h0020_2423, 32'h1234, 5'd7, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    step(); idle();
    n_tests++;
    if (out_valid !== 1'b1 || out_memwr !== 1'b1 || out_maddr !== 32'h8 || out_mdata !== 32'hDEAD_BEEF ||
        out_regwr !== 1'b0 || out_rd !== 5'd0 || out_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL store: valid=%0b memwr=%0b maddr=%h mdata=%h regwr=%0b rd=%0d wdata=%h expected 1 1 8 deadbeef 0 0 0",
               out_valid, out_memwr, out_maddr, out_mdata, out_regwr, out_rd, out_wdata);
    end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 18; i++) begin
      drive(4 * i, 32'h0000_0093 | (32'(i + 1) << 20), 32'(i), 5'd1, 1'b1, 1'b0, 0, 0);
      step();
    end
    idle();
    n_tests++;
    if (occupancy !== 5'd16 || dropped_count !== 32'd2 || overflow !== 1'b1 ||
        retired_count !== 32'd16 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: occ=%0d drop=%0d ovf=%0b ret=%0d head_pc=%h valid=%0b expected 16 2 1 16 0 1",
               occupancy, dropped_count, overflow, retired_count, out_pc, out_valid);
    end
    step();
    n_tests++;
    if (out_pc !== 32'h0 || out_wdata !== 32'd0 || occupancy !== 5'd16) begin
      n_fail++;
      $display("FAIL head_stable: pc=%h wdata=%h occ=%0d expected 0 0 16", out_pc, out_wdata, occupancy);
    end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1;
    drive(32'h400, 32'h0000_0093 | (32'd9 << 20), 32'd9, 5'd2, 1'b1, 1'b0, 0, 0);
    step(); idle(); out_ready = 0;
    n_tests++;
    if (occupancy !== 5'd16 || dropped_count !== 32'd2 || retired_count !== 32'd17 || out_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL full_push_pop: occ=%0d drop=%0d ret=%0d head_pc=%h expected 16 2 17 4",
               occupancy, dropped_count, retired_count, out_pc);
    end
    out_ready = 1;
    for (int i = 0; i < 16; i++) step();
    out_ready = 0;
    n_tests++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: occ=%0d valid=%0b expected 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_clear_then_reset();
    logic [31:0] ret0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h600 + 4 * i, 32'h0000_0093, 0, 5'd1, 1'b1, 1'b0, 0, 0);
      step();
    end
    ret0 = retired_count;
    n_tests++;
    if (occupancy !== 5'd5) begin
      n_fail++;
      $display("FAIL clear_fill: occ=%0d expected 5", occupancy);
    end
    drive(32'h700, 32'h0000_0093, 0, 5'd1, 1'b1, 1'b0, 0, 0);
    clear = 1; step(); clear = 0; idle();
    n_tests++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0 || retired_count !== ret0 ||
        dropped_count !== 32'd2 || overflow !== 1'b1 || out_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL clear: occ=%0d valid=%0b ret=%0d drop=%0d ovf=%0b pc=%h expected 0 0 %0d 2 1 0",
               occupancy, out_valid, retired_count, dropped_count, overflow, out_pc, ret0);
    end
    drive(32'h800, 32'h0000_0093, 0, 5'd1, 1'b1, 1'b0, 0, 0);
    reset = 1; step(); reset = 0; idle();
    n_tests++;
    if (retired_count !== 32'd0 || dropped_count !== 32'd0 || overflow !== 1'b0 ||
        occupancy !== 5'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_counters: ret=%0d drop=%0d ovf=%0b occ=%0d valid=%0b expected all zero",
               retired_count, dropped_count, overflow, occupancy, out_valid);
    end
  endtask

  task automatic test_rd0();
    out_ready = 1;
    drive(32'h900, 32'h0050_0013 | 32'h80, 32'h55, 5'd0, 1'b1, 1'b0, 0, 0);
    step(); idle();
    n_tests++;
    if (out_valid !== 1'b1 || out_regwr !== 1'b0 || out_wdata !== 32'd0 || out_rd !== 5'd0 || out_pc !== 32'h900) begin
      n_fail++;
      $display("FAIL rd0: valid=%0b regwr=%0b wdata=%h rd=%0d pc=%h expected 1 0 0 0 900",
               out_valid, out_regwr, out_wdata, out_rd, out_pc);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] v;
    int sel;
    for (int c = 0; c < 400; c++) begin
      rec_t e;
      sel = $urandom_range(0, 9);
      v = (sel == 0) ? 32'h13 : (sel == 1) ? 32'h0 : $urandom;
      drive($urandom, v, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 120) == 0);
      step();
      reset = 0; clear = 0;
      e = head_exp();
      n_tests++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 5'(mq.size()) || retired_count !== m_ret ||
          dropped_count !== m_drop || overflow !== m_ovf || out_pc !== e.pc || out_instr !== e.instr ||
          out_wdata !== e.wdata || out_maddr !== e.maddr || out_mdata !== e.mdata || out_rd !== e.rd ||
          out_regwr !== e.regwr || out_memwr !== e.memwr) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%0b occ=%0d ret=%0d drop=%0d ovf=%0b pc=%h instr=%h expected %0b %0d %0d %0d %0b %h %h",
                 c, out_valid, occupancy, retired_count, dropped_count, overflow, out_pc, out_instr,
                 mq.size() > 0, mq.size(), m_ret, m_drop, m_ovf, e.pc, e.instr);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_retire();
    test_bubbles();
    test_store();
    test_overflow();
    test_full_push_pop();
    test_clear_then_reset();
    test_rd0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
